// File: rtl/mul_seq_param.sv
// Iterative shift-add multiplier: retires BPC multiplier bits per cycle and
// returns either half of the 2W-bit product for MUL/MULH/MULHSU/MULHU.
module mul_seq_param #(
    parameter int unsigned W   = 32,
    parameter int unsigned BPC = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [1:0]   op,
    input  logic         flush,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         busy
);

    localparam int unsigned STEPS = W / BPC;
    localparam int unsigned CW    = $clog2(STEPS + 1);
    localparam int unsigned PW    = 2 * W;

    // Reject parameter combinations the datapath cannot support
    if (((W % BPC) != 0) || !((BPC == 1) || (BPC == 2) || (BPC == 4))) begin : g_bad_param
        $error("mul_seq_param: W must be a multiple of BPC and BPC must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_SIGN = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [W-1:0]  mcand;
    logic [W-1:0]  mplier;
    logic [PW-1:0] acc;
    logic [CW-1:0] cnt;
    logic          neg;
    logic          hi_sel;

    logic          accept_c;
    logic          sa_c;
    logic          sb_c;
    logic [W-1:0]  mag_a_c;
    logic [W-1:0]  mag_b_c;
    logic [PW-1:0] partial_c;
    logic [PW-1:0] prod_c;
    logic          calc_last_c;

    assign in_ready = (state == S_IDLE) && !rst;
    assign busy     = (state != S_IDLE);

    // Operand signedness, magnitudes and the per-cycle partial product
    always_comb begin
        accept_c    = in_valid && in_ready && !flush;
        sa_c        = (op != 2'b11);
        sb_c        = (op == 2'b00) || (op == 2'b01);
        mag_a_c     = (sa_c && a[W-1]) ? -a : a;
        mag_b_c     = (sb_c && b[W-1]) ? -b : b;
        partial_c   = (PW'(mcand) * PW'(mplier[BPC-1:0])) << (32'(cnt) * BPC);
        prod_c      = neg ? -acc : acc;
        calc_last_c = (cnt == CW'(STEPS));
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; flush overrides every transition
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (accept_c)    next_state = S_CALC;
            S_CALC: if (calc_last_c) next_state = S_SIGN;
            S_SIGN:                  next_state = S_DONE;
            S_DONE: if (out_ready)   next_state = S_IDLE;
            default:                 next_state = S_IDLE;
        endcase
        if (flush) begin
            next_state = S_IDLE;
        end
    end

    // Datapath: operand capture, shift-add accumulation, sign fix-up and result hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            cnt       <= '0;
            neg       <= 1'b0;
            hi_sel    <= 1'b0;
            result    <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= (next_state == S_DONE);
            case (state)
                S_IDLE: begin
                    if (accept_c) begin
                        mcand  <= mag_a_c;
                        mplier <= mag_b_c;
                        neg    <= (sa_c & a[W-1]) ^ (sb_c & b[W-1]);
                        hi_sel <= (op != 2'b00);
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                S_CALC: begin
                    if (!flush && !calc_last_c) begin
                        acc    <= acc + partial_c;
                        mplier <= mplier >> BPC;
                        cnt    <= cnt + CW'(1);
                    end
                end
                S_SIGN: begin
                    if (!flush) begin
                        result <= hi_sel ? prod_c[PW-1:W] : prod_c[W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq_param.sv
// Self-checking bench for mul_seq_param (W=32, BPC=2): vector table,
// handshake/flush/reset corner sequences and randomized ops vs a product model.
module tb_mul_seq_param;

    localparam int unsigned W   = 32;
    localparam int unsigned BPC = 2;
    localparam int unsigned LAT = W / BPC + 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   op;
    logic         flush;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         busy;

    int total = 0;
    int bad   = 0;

    mul_seq_param #(.W(W), .BPC(BPC)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic [1:0]   vop;
        logic [W-1:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Exact product with wide signed arithmetic, then pick the requested half
    function automatic logic [W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic [1:0] o);
        logic signed [2*W+1:0] ex;
        logic signed [2*W+1:0] ey;
        logic signed [2*W+1:0] p;
        logic sx;
        logic sy;
        sx = (o != 2'b11);
        sy = (o == 2'b00) || (o == 2'b01);
        ex = {{(W+2){sx & x[W-1]}}, x};
        ey = {{(W+2){sy & y[W-1]}}, y};
        p  = ex * ey;
        return (o == 2'b00) ? p[W-1:0] : p[2*W-1:W];
    endfunction

    // One complete transaction: accept, latency check, result check, drain
    task automatic do_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic [1:0] xop,
                         input logic [W-1:0] exp, input string tag);
        int lat;
        int waitc;
        waitc = 0;
        while (!in_ready && waitc < 50) begin
            tick();
            waitc++;
        end
        a = xa; b = xb; op = xop; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a = $urandom; b = $urandom; op = 2'($urandom);
        lat = 0;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        if (!out_valid) begin
            chk({tag, " timeout"}, W'(out_valid), W'(1));
            return;
        end
        chk({tag, " latency"}, W'(lat), W'(LAT));
        chk({tag, " result"}, result, exp);
        repeat ($urandom_range(0, 2)) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, " out_valid drop"}, W'(out_valid), W'(0));
    endtask

    vec_t vecs[10];

    initial begin
        logic [W-1:0] held;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [1:0]   rop;
        int           seen;

        vecs[0] = '{32'd7,        32'hFFFF_FFFD, 2'b00, 32'hFFFF_FFEB};
        vecs[1] = '{32'h8000_0000, 32'h8000_0000, 2'b01, 32'h4000_0000};
        vecs[2] = '{32'h8000_0000, 32'h8000_0000, 2'b00, 32'h0000_0000};
        vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, 32'hFFFF_FFFE};
        vecs[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10, 32'hFFFF_FFFF};
        vecs[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b01, 32'h0000_0000};
        vecs[6] = '{32'd7,        32'hFFFF_FFFD, 2'b01, 32'hFFFF_FFFF};
        vecs[7] = '{32'h8000_0000, 32'd2,        2'b11, 32'h0000_0001};
        vecs[8] = '{32'h1234_5678, 32'h0000_0010, 2'b00, 32'h2345_6780};
        vecs[9] = '{32'h0000_0000, 32'hDEAD_BEEF, 2'b10, 32'h0000_0000};

        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; op = 2'b00;
        #3;
        chk("reset out_valid", W'(out_valid), W'(0));
        chk("reset result", result, W'(0));
        chk("reset busy", W'(busy), W'(0));
        chk("reset in_ready", W'(in_ready), W'(0));
        #9 rst = 1'b0;
        tick();
        chk("post-reset in_ready", W'(in_ready), W'(1));

        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].va, vecs[i].vb, vecs[i].vop, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Stall in DONE while new operands are offered
        a = 32'd3; b = 32'd5; op = 2'b00; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        seen = 0;
        while (!out_valid && seen < 100) begin
            tick();
            seen++;
        end
        chk("stall reached done", W'(out_valid), W'(1));
        held = result;
        chk("stall result", held, W'(15));
        a = 32'd100; b = 32'd100; op = 2'b11; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("stall hold result c%0d", i), result, W'(15));
            chk($sformatf("stall in_ready c%0d", i), W'(in_ready), W'(0));
            chk($sformatf("stall out_valid c%0d", i), W'(out_valid), W'(1));
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("stall release out_valid", W'(out_valid), W'(0));
        chk("stall release busy", W'(busy), W'(0));
        chk("stall release in_ready", W'(in_ready), W'(1));

        // Flush during the third CALC cycle
        a = 32'd9; b = 32'd9; op = 2'b00; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush calc busy", W'(busy), W'(0));
        chk("flush calc in_ready", W'(in_ready), W'(1));
        chk("flush calc result kept", result, W'(15));
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            if (out_valid) seen++;
            tick();
        end
        chk("flush calc no out_valid", W'(seen), W'(0));

        // Flush in DONE beats out_ready; result held
        do_op(32'd6, 32'd7, 2'b00, 32'd42, "pre-flushdone");
        a = 32'd11; b = 32'd11; op = 2'b00; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        seen = 0;
        while (!out_valid && seen < 100) begin
            tick();
            seen++;
        end
        chk("flushdone result", result, W'(121));
        flush = 1'b1; out_ready = 1'b1;
        tick();
        flush = 1'b0; out_ready = 1'b0;
        chk("flushdone out_valid", W'(out_valid), W'(0));
        chk("flushdone result held", result, W'(121));
        chk("flushdone busy", W'(busy), W'(0));

        // Flush in IDLE blocks capture
        a = 32'd2; b = 32'd2; in_valid = 1'b1; flush = 1'b1;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        chk("flush idle no capture", W'(busy), W'(0));

        // Asynchronous reset in the middle of CALC
        a = 32'd5; b = 32'd5; op = 2'b00; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        #2 rst = 1'b1;
        #1;
        chk("mid rst out_valid", W'(out_valid), W'(0));
        chk("mid rst result", result, W'(0));
        chk("mid rst busy", W'(busy), W'(0));
        chk("mid rst in_ready", W'(in_ready), W'(0));
        #3 rst = 1'b0;
        tick();
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            if (out_valid) seen++;
            tick();
        end
        chk("mid rst no out_valid", W'(seen), W'(0));

        // Randomized operations with a bias toward corner operands
        for (int i = 0; i < 300; i++) begin
            ra  = $urandom;
            rb  = $urandom;
            rop = 2'($urandom);
            case ($urandom_range(0, 7))
                0: ra = 32'h8000_0000;
                1: rb = 32'hFFFF_FFFF;
                2: begin ra = 32'h8000_0000; rb = 32'h8000_0000; end
                3: rb = 32'd0;
                default: ;
            endcase
            do_op(ra, rb, rop, ref_mul(ra, rb, rop), $sformatf("rand%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
